// File: rtl/clk_period_monitor.sv
// Clock period monitor: measures the rise-to-rise period of an asynchronous inclk in clk cycles
// and locks when it stays near EXP_PERIOD. Define PERIOD_MON_DUTY_EN to also measure high time.
module clk_period_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned EXP_PERIOD  = 16,
    parameter int unsigned TOL         = 1,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inclk,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [CNT_W-1:0] high_time,
    output logic             high_valid,
    output logic             locked,
    output logic             lost
);

    localparam int unsigned      MCNT_W   = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   LO_BOUND = (EXP_PERIOD > TOL) ? (CNT_W+1)'(EXP_PERIOD - TOL) : '0;
    localparam logic [CNT_W:0]   HI_BOUND = (CNT_W+1)'(EXP_PERIOD + TOL);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       period_meas_c;
    logic                   in_range_c;
    logic                   timeout_hit_c;

    state_t                 state_q, state_d;
    logic [MCNT_W-1:0]      mcnt_q, mcnt_d;
    logic [MCNT_W-1:0]      mcnt_inc_c;
    logic                   meas_en_c;
    logic                   lost_c;

    // Synchronizer; the edge pulses compare the stage pair one step early so they leave a register
    // with the same timing as a last-stage/delay-flop compare.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= '0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], inclk};
            rise_pulse <= sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
            fall_pulse <= ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];
        end
    end

    // Free-running cycle counter, restarted by every rise and saturating at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (rise_pulse) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        period_meas_c = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
        in_range_c    = ({1'b0, period_meas_c} >= LO_BOUND) && ({1'b0, period_meas_c} <= HI_BOUND);
        timeout_hit_c = (cnt_q == CNT_W'(TIMEOUT));
        mcnt_inc_c    = mcnt_q + MCNT_W'(1);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
        end
    end

    // Next state; a rise always wins over a coincident timeout
    always_comb begin
        state_d   = state_q;
        mcnt_d    = mcnt_q;
        meas_en_c = 1'b0;
        lost_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise_pulse) begin
                    state_d = ACQ;
                    mcnt_d  = '0;
                end
            end
            ACQ: begin
                if (rise_pulse) begin
                    meas_en_c = 1'b1;
                    if (in_range_c) begin
                        mcnt_d = mcnt_inc_c;
                        if (mcnt_inc_c >= MCNT_W'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        mcnt_d = '0;
                    end
                end else if (timeout_hit_c) begin
                    lost_c  = 1'b1;
                    state_d = IDLE;
                    mcnt_d  = '0;
                end
            end
            LOCKED: begin
                if (rise_pulse) begin
                    meas_en_c = 1'b1;
                    if (!in_range_c) begin
                        state_d = ACQ;
                        mcnt_d  = '0;
                    end
                end else if (timeout_hit_c) begin
                    lost_c  = 1'b1;
                    state_d = IDLE;
                    mcnt_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                mcnt_d  = '0;
            end
        endcase
    end

    // Registered status outputs; locked tracks the state entered on this edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
        end else begin
            period_valid <= meas_en_c;
            locked       <= (state_d == LOCKED);
            lost         <= lost_c;
            if (meas_en_c) begin
                period <= period_meas_c;
            end
        end
    end

`ifdef PERIOD_MON_DUTY_EN
    logic [CNT_W-1:0] hcnt_q;
    logic             harm_q;

    // High-time counter: armed by a rise, sampled by the following fall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_q     <= '0;
            harm_q     <= 1'b0;
            high_time  <= '0;
            high_valid <= 1'b0;
        end else begin
            high_valid <= 1'b0;
            if (rise_pulse) begin
                hcnt_q <= '0;
                harm_q <= 1'b1;
            end else begin
                if (hcnt_q != CNT_MAX) begin
                    hcnt_q <= hcnt_q + CNT_W'(1);
                end
                if (fall_pulse && harm_q) begin
                    high_time  <= (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + CNT_W'(1);
                    high_valid <= 1'b1;
                    harm_q     <= 1'b0;
                end
            end
        end
    end
`else
    assign high_time  = '0;
    assign high_valid = 1'b0;
`endif

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor with default parameters; inclk is driven on clk negedges.
module tb_clk_period_monitor;

    logic       clk;
    logic       rst;
    logic       inclk;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] period;
    logic       period_valid;
    logic [7:0] high_time;
    logic       high_valid;
    logic       locked;
    logic       lost;

    int checks = 0;
    int errors = 0;

    int   pv_cnt   = 0;
    int   lost_cnt = 0;
    int   rise_cnt = 0;
    int   fall_cnt = 0;
    int   hv_cnt   = 0;
    logic pv_locked = 1'b0;

    clk_period_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .inclk        (inclk),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .period       (period),
        .period_valid (period_valid),
        .high_time    (high_time),
        .high_valid   (high_valid),
        .locked       (locked),
        .lost         (lost)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Event counters, sampled away from the active edge
    always @(negedge clk) begin
        if (period_valid) begin
            pv_cnt    <= pv_cnt + 1;
            pv_locked <= locked;
        end
        if (lost)       lost_cnt <= lost_cnt + 1;
        if (rise_pulse) rise_cnt <= rise_cnt + 1;
        if (fall_pulse) fall_cnt <= fall_cnt + 1;
        if (high_valid) hv_cnt   <= hv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rise"},   32'(rise_pulse),   0);
        check({tag, ".fall"},   32'(fall_pulse),   0);
        check({tag, ".period"}, 32'(period),       0);
        check({tag, ".pv"},     32'(period_valid), 0);
        check({tag, ".high"},   32'(high_time),    0);
        check({tag, ".hv"},     32'(high_valid),   0);
        check({tag, ".locked"}, 32'(locked),       0);
        check({tag, ".lost"},   32'(lost),         0);
    endtask

    // One inclk period starting with a rise; expectations refer to the measurement this rise produces
    task automatic per(input int hi, input int lo, input bit exp_pv, input int exp_period,
                       input bit exp_locked, input string tag);
        int n0;
        n0 = pv_cnt;
        inclk = 1'b1;
        repeat (hi) @(negedge clk);
        inclk = 1'b0;
        repeat (lo) @(negedge clk);
        check({tag, ".npv"}, 32'(pv_cnt - n0), 32'(exp_pv));
        check({tag, ".locked"}, 32'(locked), 32'(exp_locked));
        if (exp_pv) begin
            check({tag, ".period"}, 32'(period), 32'(exp_period));
            check({tag, ".lk_at_pv"}, 32'(pv_locked), 32'(exp_locked));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired got 0 exp 1");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int l0;
        rst   = 1'b0;
        inclk = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // First rise from IDLE, with synchronizer latency checked edge by edge
        n0 = pv_cnt;
        inclk = 1'b1;
        @(posedge clk); #1 check("rise.k",  32'(rise_pulse), 0);
        @(posedge clk); #1 check("rise.k1", 32'(rise_pulse), 1);
        @(posedge clk); #1 check("rise.k2", 32'(rise_pulse), 0);
        repeat (6) @(negedge clk);
        inclk = 1'b0;
        repeat (8) @(negedge clk);
        check("c1.npv", 32'(pv_cnt - n0), 0);
        check("c1.locked", 32'(locked), 0);

        // 16-cycle clock locks on the 4th measurement
        per(8, 8, 1, 16, 0, "c2");
        per(8, 8, 1, 16, 0, "c3");
        per(8, 8, 1, 16, 0, "c4");
        per(8, 8, 1, 16, 1, "c5");
        check("a.rises", 32'(rise_cnt), 5);
        check("a.falls", 32'(fall_cnt), 5);
`ifdef PERIOD_MON_DUTY_EN
        check("a.high_time", 32'(high_time), 8);
        check("a.hv", 32'(hv_cnt), 5);
`else
        check("a.high_time", 32'(high_time), 0);
        check("a.hv", 32'(hv_cnt), 0);
`endif

        // One 20-cycle period drops lock, four good ones relock
        per(12, 8, 1, 16, 1, "c6");
        per(8, 8, 1, 20, 0, "c7");
        per(8, 8, 1, 16, 0, "c8");
        per(8, 8, 1, 16, 0, "c9");
        per(8, 8, 1, 16, 0, "c10");
        per(8, 6, 1, 16, 1, "c11");

        // 14 and 18 rejected; 15 and 17 accepted
        per(8, 10, 1, 14, 0, "c12");
        per(8, 7, 1, 18, 0, "c13");
        per(8, 9, 1, 15, 0, "c14");
        per(8, 7, 1, 17, 0, "c15");
        per(8, 9, 1, 15, 0, "c16");
        per(8, 8, 1, 17, 1, "c17");
        per(8, 8, 1, 16, 1, "c18");

        // inclk stops: one lost pulse, period held, relock sequence restarts from IDLE
        l0 = lost_cnt;
        repeat (120) @(negedge clk);
        check("stop.lost_cnt", 32'(lost_cnt - l0), 1);
        check("stop.lost_now", 32'(lost), 0);
        check("stop.locked", 32'(locked), 0);
        check("stop.period", 32'(period), 16);
        per(8, 8, 0, 0, 0, "c19");
        per(8, 8, 1, 16, 0, "c20");

        // 65-cycle period puts the rise on the timeout cycle: no lost, stays out of IDLE
        l0 = lost_cnt;
        per(8, 57, 1, 16, 0, "c21");
        per(8, 8, 1, 65, 0, "c22");
        check("coin.lost_cnt", 32'(lost_cnt - l0), 0);
        per(8, 8, 1, 16, 0, "c23");

        // Asynchronous reset while locked
        per(8, 8, 1, 16, 0, "c24");
        per(8, 8, 1, 16, 0, "c25");
        per(8, 8, 1, 16, 1, "c26");
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        per(8, 8, 0, 0, 0, "c27");
        per(8, 8, 1, 16, 0, "c28");
        per(8, 8, 1, 16, 0, "c29");
        per(8, 8, 1, 16, 0, "c30");
        per(8, 8, 1, 16, 1, "c31");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_period_monitor.md
CLK_PERIOD_MONITOR -- requirements
Module: clk_period_monitor

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for inclk, minimum 2.
REQ-002 Parameter CNT_W, default 8: width of the cycle counter, period and high_time.
REQ-003 Parameter EXP_PERIOD, default 16: expected inclk period in clk cycles.
REQ-004 Parameter TOL, default 1: accepted deviation, in clk cycles, from EXP_PERIOD.
REQ-005 Parameter LOCK_COUNT, default 4: consecutive in-range periods required to lock.
REQ-006 Parameter TIMEOUT, default 64: clk cycles without a rise before loss; must be less than 2^CNT_W.
REQ-007 clk  input  1  system clock; all state changes on its rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-low.
REQ-009 inclk  input  1  divided clock under test, asynchronous to clk.
REQ-010 rise_pulse  output  1  one-cycle strobe per synchronized inclk rising edge.
REQ-011 fall_pulse  output  1  one-cycle strobe per synchronized inclk falling edge.
REQ-012 period  output  CNT_W  last measured rise-to-rise interval, in clk cycles.
REQ-013 period_valid  output  1  one-cycle strobe marking an update of period.
REQ-014 high_time  output  CNT_W  last measured rise-to-fall interval, in clk cycles.
REQ-015 high_valid  output  1  one-cycle strobe marking an update of high_time.
REQ-016 locked  output  1  high while the FSM is in LOCKED.
REQ-017 lost  output  1  one-cycle strobe on timeout.

Function
REQ-018 inclk SHALL pass through SYNC_STAGES flops plus one delay flop; rise_pulse is asserted when the last stage is 1 and the delay flop is 0; fall_pulse is the inverse case; both outputs come from registers.
REQ-019 If inclk settles 0->1 before clk edge k, rise_pulse SHALL be high between edges k+SYNC_STAGES-1 and k+SYNC_STAGES.
REQ-020 Cycle counter cnt SHALL clear to 0 in a rise_pulse cycle, otherwise increment by 1, and saturate at 2^CNT_W-1.
REQ-021 On a rise_pulse, except the first one after entering IDLE, the block SHALL register period as cnt+1 (saturating) and pulse period_valid in the next cycle; a 16-cycle inclk therefore yields period=16.
REQ-022 The FSM SHALL have states IDLE, ACQ and LOCKED, plus a match counter mcnt.
REQ-023 IDLE: on rise_pulse, go to ACQ with mcnt set to 0; no period_valid is produced.
REQ-024 A period is in range when EXP_PERIOD-TOL <= period <= EXP_PERIOD+TOL; both bounds are inclusive.
REQ-025 ACQ: an in-range period SHALL increment mcnt; when mcnt reaches LOCK_COUNT, go to LOCKED; an out-of-range period SHALL clear mcnt.
REQ-026 LOCKED: an out-of-range period SHALL move the FSM to ACQ with mcnt set to 0.
REQ-027 locked SHALL change on the same clk edge that presents the deciding period/period_valid.
REQ-028 In ACQ or LOCKED, when cnt reaches TIMEOUT, the block SHALL pulse lost for one cycle, go to IDLE and clear mcnt; IDLE never times out.
REQ-029 If a rise_pulse and the timeout condition coincide, the rise SHALL take priority and no lost pulse is produced.
REQ-030 period and high_time SHALL hold their last values until the next update, including across lost.

Reset
REQ-031 While rst=0, the block SHALL immediately clear the synchronizer, cnt, mcnt and all outputs to 0 and hold the FSM in IDLE.
REQ-032 After rst deasserts, the first rise_pulse SHALL NOT produce period_valid; a reset asserted mid-measurement discards the partial count.

Configuration
REQ-033 With PERIOD_MON_DUTY_EN defined, a rise SHALL start a high counter; on fall_pulse, high_time is set to the count of clk cycles from rise to fall and high_valid pulses in the next cycle; a 16-cycle inclk with 8 cycles high gives high_time=8.
REQ-034 Without PERIOD_MON_DUTY_EN, high_time and high_valid SHALL be tied to 0, no high-counter logic is present, and fall_pulse is still generated.

Verification
REQ-035 Reset, then an inclk of 8 low / 8 high (default parameters) -> every period_valid shows 16; locked=1 at the 4th period_valid (5th rise); high_time=8 with PERIOD_MON_DUTY_EN defined.
REQ-036 Periods of 15 and 17 -> accepted and the block locks; periods of 14 and 18 -> period_valid with the value, locked stays 0.
REQ-037 Locked, then one 20-cycle period -> locked=0 on the edge that presents period=20; relocks after 4 further 16-cycle periods.
REQ-038 Locked, then inclk held constant -> lost pulses once when cnt reaches 64 and locked=0; the next rise gives no period_valid, and the following rise gives period_valid.
REQ-039 rst pulsed low while locked -> all outputs are 0 asynchronously; after release, the first rise gives no period_valid and lock needs 4 good periods.
REQ-040 A rise_pulse in the same cycle that cnt reaches TIMEOUT -> no lost pulse and the FSM stays out of IDLE.
